vram_mux_sequencer: RTL and testbench

Sequences the character-memory address multiplexer (bank of quad 2:1 muxes, select `s`, enable `e_n`) between display refresh reads and terminal character writes. Latches both candidate addresses, drives mux select/enable and the memory write strobe, and captures refresh data for the character generator. Display refresh has priority; writes fill idle cycles and are acknowledged by handshake.

---
 rtl/vram_mux_sequencer.sv | 151 +++++++++++++++
 tb/tb_vram_mux_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_mux_sequencer.sv
// Arbitrates the character-memory address mux between display refresh reads
// and terminal writes; refresh has priority and writes fill idle cycles.
module vram_mux_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              char_tick,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] rd_addr_q,
  output logic [ADDR_W-1:0] wr_addr_q,
  output logic              mux_sel,
  output logic              mux_en_n,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              wr_ack,
  output logic [DATA_W-1:0] disp_char,
  output logic              disp_valid,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_SETUP, WR_STROBE, WR_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              rd_pending_q, rd_pending_d;
  logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] disp_char_q, disp_char_d;
  logic              overrun_q, overrun_d;
  logic              mux_sel_q, mux_sel_d;
  logic              mux_en_n_q, mux_en_n_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_ack_q, wr_ack_d;
  logic              disp_valid_q, disp_valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    rd_pending_d = rd_pending_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    mem_wdata_d  = mem_wdata_q;
    disp_char_d  = disp_char_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (char_tick || rd_pending_q) begin
          if (char_tick && !rd_pending_q) rd_addr_d = disp_addr;
          if (char_tick && rd_pending_q)  overrun_d = 1'b1;
          rd_pending_d = 1'b0;
          state_d      = RD_ADDR;
        end else if (wr_req) begin
          wr_addr_d   = wr_addr;
          mem_wdata_d = wr_data;
          state_d     = WR_SETUP;
        end
      end
      RD_ADDR: begin
        if (char_tick) overrun_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (char_tick) overrun_d = 1'b1;
        disp_char_d = mem_rdata;
        state_d     = IDLE;
      end
      WR_SETUP, WR_STROBE, WR_HOLD: begin
        // A tick during a write is parked in rd_pending; only one can wait.
        if (char_tick) begin
          if (rd_pending_q) begin
            overrun_d = 1'b1;
          end else begin
            rd_pending_d = 1'b1;
            rd_addr_d    = disp_addr;
          end
        end
        if (state_q == WR_SETUP) begin
          state_d = WR_STROBE;
        end else if (state_q == WR_STROBE) begin
          state_d = WR_HOLD;
        end else if (rd_pending_d) begin
          rd_pending_d = 1'b0;
          state_d      = RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    mux_sel_d    = (state_d == WR_SETUP) || (state_d == WR_STROBE) || (state_d == WR_HOLD);
    mux_en_n_d   = (state_d == IDLE);
    mem_we_d     = (state_d == WR_STROBE);
    wr_ack_d     = (state_d == WR_HOLD);
    busy_d       = (state_d != IDLE);
    disp_valid_d = (state_q == RD_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      mem_wdata_q  <= '0;
      disp_char_q  <= '0;
      overrun_q    <= 1'b0;
      mux_sel_q    <= 1'b0;
      mux_en_n_q   <= 1'b1;
      mem_we_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_char_q  <= disp_char_d;
      overrun_q    <= overrun_d;
      mux_sel_q    <= mux_sel_d;
      mux_en_n_q   <= mux_en_n_d;
      mem_we_q     <= mem_we_d;
      wr_ack_q     <= wr_ack_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign mux_en_n   = mux_en_n_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_ack     = wr_ack_q;
  assign disp_char  = disp_char_q;
  assign disp_valid = disp_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vram_mux_sequencer.sv
// Bench for vram_mux_sequencer: directed scenarios plus random traffic against
// a memory-cycle scheduler model (operation kind + phase count).
module tb_vram_mux_sequencer;

  localparam int AW = 10;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          reset, char_tick, wr_req;
  logic [AW-1:0] disp_addr, wr_addr;
  logic [DW-1:0] wr_data, mem_rdata;
  logic [AW-1:0] rd_addr_q, wr_addr_q;
  logic          mux_sel, mux_en_n, mem_we, wr_ack, disp_valid, overrun, busy;
  logic [DW-1:0] mem_wdata, disp_char;

  vram_mux_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .char_tick(char_tick), .disp_addr(disp_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .mem_rdata(mem_rdata),
    .rd_addr_q(rd_addr_q), .wr_addr_q(wr_addr_q), .mux_sel(mux_sel),
    .mux_en_n(mux_en_n), .mem_we(mem_we), .mem_wdata(mem_wdata), .wr_ack(wr_ack),
    .disp_char(disp_char), .disp_valid(disp_valid), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: m_op 0=no memory cycle, 1=read, 2=write; m_ph counts cycles into it.
  int            m_op, m_ph;
  bit            m_pend, m_valid, m_ovr;
  logic [AW-1:0] m_rd_addr, m_wr_addr;
  logic [DW-1:0] m_wdata, m_char;

  task automatic model_reset();
    m_op = 0; m_ph = 0; m_pend = 0; m_valid = 0; m_ovr = 0;
    m_rd_addr = '0; m_wr_addr = '0; m_wdata = '0; m_char = '0;
  endtask

  task automatic model_update();
    if (reset) begin
      model_reset();
      return;
    end
    m_valid = 0;
    if (m_op == 1) begin
      if (char_tick) m_ovr = 1;
      if (m_ph == 2) begin
        m_char = mem_rdata; m_valid = 1; m_op = 0;
      end else m_ph++;
    end else if (m_op == 2) begin
      if (char_tick) begin
        if (m_pend) m_ovr = 1;
        else begin m_pend = 1; m_rd_addr = disp_addr; end
      end
      if (m_ph < 3) m_ph++;
      else if (m_pend) begin m_pend = 0; m_op = 1; m_ph = 1; end
      else m_op = 0;
    end else begin
      if (char_tick || m_pend) begin
        if (char_tick && m_pend) m_ovr = 1;
        else if (char_tick) m_rd_addr = disp_addr;
        m_pend = 0; m_op = 1; m_ph = 1;
      end else if (wr_req) begin
        m_wr_addr = wr_addr; m_wdata = wr_data; m_op = 2; m_ph = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("rd_addr",    32'(rd_addr_q),  32'(m_rd_addr));
    chk("wr_addr",    32'(wr_addr_q),  32'(m_wr_addr));
    chk("mem_wdata",  32'(mem_wdata),  32'(m_wdata));
    chk("mux_sel",    32'(mux_sel),    32'(m_op == 2));
    chk("mux_en_n",   32'(mux_en_n),   32'(m_op == 0));
    chk("mem_we",     32'(mem_we),     32'(m_op == 2 && m_ph == 2));
    chk("wr_ack",     32'(wr_ack),     32'(m_op == 2 && m_ph == 3));
    chk("disp_char",  32'(disp_char),  32'(m_char));
    chk("disp_valid", 32'(disp_valid), 32'(m_valid));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("busy",       32'(busy),       32'(m_op != 0));
    chk("we_sel",     32'(mem_we & ~mux_sel), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  logic [31:0] r;
  int          gap;

  initial begin
    reset = 1; char_tick = 0; wr_req = 0;
    disp_addr = '0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    step(); step();
    reset = 0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_en_n",  32'(mux_en_n),  32'd1);
    chk("rst_we",    32'(mem_we),    32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_char",  32'(disp_char), 32'd0);
    chk("rst_rdadr", 32'(rd_addr_q), 32'd0);

    // Display read from idle
    char_tick = 1; disp_addr = 10'h123; mem_rdata = 7'h41;
    step(); char_tick = 0; disp_addr = 10'h000;
    chk("rd_t1_addr", 32'(rd_addr_q), 32'h123);
    chk("rd_t1_sel",  32'(mux_sel),   32'd0);
    chk("rd_t1_en",   32'(mux_en_n),  32'd0);
    step();
    chk("rd_t2_en",   32'(mux_en_n),  32'd0);
    step();
    chk("rd_t3_vld",  32'(disp_valid), 32'd1);
    chk("rd_t3_char", 32'(disp_char),  32'h41);
    step();
    chk("rd_t4_vld",  32'(disp_valid), 32'd0);

    // Write from idle
    wr_req = 1; wr_addr = 10'h3FF; wr_data = 7'h5A;
    step();
    chk("wr_t1_sel", 32'(mux_sel), 32'd1);
    chk("wr_t1_we",  32'(mem_we),  32'd0);
    step();
    chk("wr_t2_we",  32'(mem_we),    32'd1);
    chk("wr_t2_dat", 32'(mem_wdata), 32'h5A);
    chk("wr_t2_adr", 32'(wr_addr_q), 32'h3FF);
    step();
    chk("wr_t3_ack", 32'(wr_ack), 32'd1);
    chk("wr_t3_we",  32'(mem_we), 32'd0);
    chk("wr_t3_sel", 32'(mux_sel), 32'd1);
    wr_req = 0;
    step();
    chk("wr_t4_en",  32'(mux_en_n), 32'd1);

    // Read and write requested together: read first
    char_tick = 1; disp_addr = 10'h055; wr_req = 1; wr_addr = 10'h0AA; wr_data = 7'h33;
    mem_rdata = 7'h12;
    step(); char_tick = 0;
    step(); step();
    chk("both_t3_vld", 32'(disp_valid), 32'd1);
    step();
    chk("both_t4_sel", 32'(mux_sel), 32'd1);
    step(); step();
    chk("both_t6_ack", 32'(wr_ack), 32'd1);
    wr_req = 0;
    step();

    // Tick during WR_STROBE, then overrun by ticks two cycles apart
    wr_req = 1; wr_addr = 10'h201; wr_data = 7'h07;
    step(); step();
    char_tick = 1; disp_addr = 10'h2C4; mem_rdata = 7'h29;
    step(); char_tick = 0;
    chk("def_ack", 32'(wr_ack), 32'd1);
    wr_req = 0;
    step();
    chk("def_rd_sel", 32'(mux_sel),   32'd0);
    chk("def_rd_en",  32'(mux_en_n),  32'd0);
    chk("def_rdadr",  32'(rd_addr_q), 32'h2C4);
    step(); step();
    chk("def_vld",    32'(disp_valid), 32'd1);
    chk("def_char",   32'(disp_char),  32'h29);
    char_tick = 1; step(); char_tick = 0;
    step();
    char_tick = 1; step(); char_tick = 0;
    chk("ovr_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset during WR_STROBE
    wr_req = 1; wr_addr = 10'h111; wr_data = 7'h22;
    step(); step();
    chk("rw_we", 32'(mem_we), 32'd1);
    reset = 1;
    step();
    reset = 0; wr_req = 0;
    chk("rw_we0",  32'(mem_we),   32'd0);
    chk("rw_en",   32'(mux_en_n), 32'd1);
    chk("rw_ack",  32'(wr_ack),   32'd0);
    chk("rw_busy", 32'(busy),     32'd0);
    chk("rw_ovr",  32'(overrun),  32'd0);
    step();
    chk("rw_ack2", 32'(wr_ack),   32'd0);

    // Random traffic
    gap = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom; disp_addr = r[AW-1:0];
      r = $urandom; mem_rdata = r[DW-1:0];
      reset = ($urandom_range(0, 499) == 0);
      if (gap == 0) begin
        char_tick = 1; gap = $urandom_range(1, 11);
      end else begin
        char_tick = 0; gap--;
      end
      if (wr_req && wr_ack) wr_req = 0;
      else if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1;
        r = $urandom; wr_addr = r[AW-1:0];
        r = $urandom; wr_data = r[DW-1:0];
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
